// File: rtl/sawtooth_gen_param.sv
// Sawtooth / ramp generator with button-loaded bounds N1/N2 and a prescaled step.
// Optional triangle mode is enabled by defining SAWTOOTH_TRIANGLE_EN (adds tri_i).
module sawtooth_gen_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 12500000,
   parameter int unsigned DOWN  = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             v_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] n1_o,
   output logic [WIDTH-1:0] n2_o,
   output logic [WIDTH-1:0] dind_o,
   output logic             wrap_o,
   output logic             err_o,
   output logic [1:0]       state_o
`ifdef SAWTOOTH_TRIANGLE_EN
   ,
   input  logic             tri_i
`endif
);

   localparam int unsigned   PW    = $clog2(DIV);
   localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      LOAD_N1 = 2'b00,
      LOAD_N2 = 2'b01,
      RUN     = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic             v_q;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] n1_q, n1_d;
   logic [WIDTH-1:0] n2_q, n2_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
`ifdef SAWTOOTH_TRIANGLE_EN
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] back_cnt;
`endif

   logic             sel;
   logic             in_run;
   logic             tick;
   logic             bad_bounds;
   logic [WIDTH-1:0] start_b, end_b, fwd_cnt;
   logic [WIDTH-1:0] saw_cnt;
   logic             saw_wrap;

   assign sel        = v_i & ~v_q;
   assign in_run     = (state_q == RUN);
   assign tick       = in_run && (presc_q == PLAST);
   assign bad_bounds = (n1_q >= n2_q);

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= LOAD_N1;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD_N1: if (sel) state_d = LOAD_N2;
         LOAD_N2: if (sel) state_d = RUN;
         RUN:     if (sel) state_d = LOAD_N1;
         default: state_d = LOAD_N1;
      endcase
   end

   // FSM: outputs
   always_comb begin
      state_o = state_q;
      dind_o  = in_run ? cnt_q : din_i;
      err_o   = in_run && bad_bounds;
   end

   // Prescaler only advances in RUN and restarts on any state change
   always_comb begin
      presc_d = '0;
      if ((state_d == state_q) && in_run && !tick) begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Direction-normalised view: "start" is where the ramp begins, "end" where it wraps
   always_comb begin
      if (DOWN != 0) begin
         start_b = n2_q;
         end_b   = n1_q;
         fwd_cnt = cnt_q - WIDTH'(1);
      end else begin
         start_b = n1_q;
         end_b   = n2_q;
         fwd_cnt = cnt_q + WIDTH'(1);
      end
      saw_wrap = (cnt_q == end_b);
      saw_cnt  = saw_wrap ? start_b : fwd_cnt;
   end

`ifdef SAWTOOTH_TRIANGLE_EN
   assign back_cnt = (DOWN != 0) ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
`endif

   always_comb begin
      n1_d   = n1_q;
      n2_d   = n2_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
`ifdef SAWTOOTH_TRIANGLE_EN
      dir_d  = dir_q;
`endif
      case (state_q)
         LOAD_N1: begin
            if (sel) n1_d = din_i;
         end
         LOAD_N2: begin
            if (sel) begin
               n2_d  = din_i;
               cnt_d = (DOWN != 0) ? din_i : n1_q;
`ifdef SAWTOOTH_TRIANGLE_EN
               dir_d = 1'b0;
`endif
            end
         end
         RUN: begin
            // A select event freezes the counter and swallows any coincident tick
            if (!sel) begin
               if (bad_bounds) begin
                  cnt_d = n1_q;
               end else if (tick) begin
`ifdef SAWTOOTH_TRIANGLE_EN
                  if (tri_i) begin
                     if (!dir_q) begin
                        if (cnt_q == end_b) begin
                           dir_d  = 1'b1;
                           cnt_d  = back_cnt;
                           wrap_d = (back_cnt == start_b);
                        end else begin
                           cnt_d = fwd_cnt;
                        end
                     end else begin
                        if (cnt_q == start_b) begin
                           dir_d = 1'b0;
                           cnt_d = fwd_cnt;
                        end else begin
                           cnt_d  = back_cnt;
                           wrap_d = (back_cnt == start_b);
                        end
                     end
                  end else begin
                     dir_d  = 1'b0;
                     cnt_d  = saw_cnt;
                     wrap_d = saw_wrap;
                  end
`else
                  cnt_d  = saw_cnt;
                  wrap_d = saw_wrap;
`endif
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v_q     <= 1'b0;
         presc_q <= '0;
         n1_q    <= '0;
         n2_q    <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
`ifdef SAWTOOTH_TRIANGLE_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         v_q     <= v_i;
         presc_q <= presc_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
`ifdef SAWTOOTH_TRIANGLE_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign cnt_o  = cnt_q;
   assign n1_o   = n1_q;
   assign n2_o   = n2_q;
   assign wrap_o = wrap_q;

endmodule
